multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: 12-state FSM sequencing fetch, decode,
// memory, ALU, branch and jump steps, with handshaked waits on unified memory.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_write,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    logic   pc_write;
    logic   branch;

    function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
        case (f)
            6'b100000: return ALU_ADD;
            6'b100010: return ALU_SUB;
            6'b100100: return ALU_AND;
            6'b100101: return ALU_OR;
            6'b101010: return ALU_SLT;
            default:   return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:   if (mem_ready) state_q <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_RTYPE:     state_q <= EXECUTE;
                        OP_BEQ:       state_q <= BRANCH;
                        OP_ADDI:      state_q <= ADDIEX;
                        OP_J:         state_q <= JUMP;
                        default:      state_q <= FETCH;
                    endcase
                end
                MEMADR:  state_q <= (opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (mem_ready) state_q <= MEMWB;
                MEMWB:   state_q <= FETCH;
                MEMWR:   if (mem_ready) state_q <= FETCH;
                EXECUTE: state_q <= ALUWB;
                ALUWB:   state_q <= FETCH;
                BRANCH:  state_q <= FETCH;
                ADDIEX:  state_q <= ADDIWB;
                ADDIWB:  state_q <= FETCH;
                JUMP:    state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        pc_src      = 2'b00;
        illegal_op  = 1'b0;

        case (state_q)
            FETCH: begin
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                ir_write    = mem_ready;
                pc_write    = mem_ready;
            end
            DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default:                                        illegal_op = 1'b1;
                endcase
            end
            MEMADR, ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = funct_to_alu(funct);
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                branch      = 1'b1;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase

        pc_en = pc_write | (branch & zero);

        // FETCH strobes follow mem_ready directly, so reset must mask them too
        if (!rst_n) begin
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction state paths and a
// per-state output table, driven with directed and randomized instructions.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       illegal_op;
    logic [3:0] state;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       illegal_op;
    } outs_t;

    int errors = 0;
    int checks = 0;
    int exp_path[$];
    int cnt_mw, cnt_rw, cnt_il, cnt_pc;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write),
        .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_src(pc_src), .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t observed();
        return {pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_control, pc_src, illegal_op};
    endfunction

    function automatic logic [2:0] spec_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Output table: what each state drives, per the written control description.
    function automatic outs_t exp_out(input int st, input logic [5:0] op, input logic [5:0] fn,
                                      input logic z, input logic mr, input logic rn);
        outs_t o;
        o = '0;
        case (st)
            0:  begin o.alu_src_b = 2'b01; o.alu_control = 3'b010; o.ir_write = mr; o.pc_en = mr; end
            1:  begin
                    o.alu_src_b = 2'b11; o.alu_control = 3'b010;
                    o.illegal_op = !(op inside {6'b100011, 6'b101011, 6'b000000,
                                                6'b000100, 6'b001000, 6'b000010});
                end
            2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_control = 3'b010; end
            3:  o.iord = 1'b1;
            4:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            5:  begin o.iord = 1'b1; o.mem_write = 1'b1; end
            6:  begin o.alu_src_a = 1'b1; o.alu_control = spec_alu(fn); end
            7:  begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
            8:  begin o.alu_src_a = 1'b1; o.alu_control = 3'b110; o.pc_src = 2'b01; o.pc_en = z; end
            9:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_control = 3'b010; end
            10: o.reg_write = 1'b1;
            11: begin o.pc_src = 2'b10; o.pc_en = 1'b1; end
            default: ;
        endcase
        if (!rn) begin
            o.pc_en = 1'b0; o.ir_write = 1'b0; o.mem_write = 1'b0;
            o.reg_write = 1'b0; o.illegal_op = 1'b0;
        end
        return o;
    endfunction

    task automatic build_path(input logic [5:0] op);
        case (op)
            6'b100011: exp_path = {0, 1, 2, 3, 4};
            6'b101011: exp_path = {0, 1, 2, 5};
            6'b000000: exp_path = {0, 1, 6, 7};
            6'b000100: exp_path = {0, 1, 8};
            6'b001000: exp_path = {0, 1, 9, 10};
            6'b000010: exp_path = {0, 1, 11};
            default:   exp_path = {0, 1};
        endcase
    endtask

    // Walks one instruction from FETCH, stalling wait states by the given counts.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int unsigned fstall, input int unsigned mstall, input string tag);
        outs_t exp, obs;
        int st;
        int unsigned waits;
        bit wait_state;
        build_path(op);
        cnt_mw = 0; cnt_rw = 0; cnt_il = 0; cnt_pc = 0;
        for (int i = 0; i < exp_path.size(); i++) begin
            st = exp_path[i];
            wait_state = (st == 0 || st == 3 || st == 5);
            waits = (st == 0) ? fstall : (wait_state ? mstall : 0);
            for (int unsigned c = 0; c <= waits; c++) begin
                @(negedge clk);
                opcode = op; funct = fn; zero = z;
                mem_ready = wait_state ? (c == waits) : 1'($urandom_range(0, 1));
                #1;
                checks++;
                if (state !== st[3:0]) begin
                    errors++;
                    $display("FAIL %s state step=%0d wait=%0d: got %0d expected %0d", tag, i, c, state, st);
                end
                exp = exp_out(st, op, fn, z, mem_ready, 1'b1);
                obs = observed();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL %s outputs state=%0d wait=%0d: got %h expected %h", tag, st, c, obs, exp);
                end
                cnt_mw += int'(mem_write);
                cnt_rw += int'(reg_write);
                cnt_il += int'(illegal_op);
                cnt_pc += int'(pc_en);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b100011; funct = '0; zero = 1'b1;
        #3;
        checks++;
        if (state !== 4'd0 || {pc_en, ir_write, mem_write, reg_write, illegal_op} !== 5'b0) begin
            errors++;
            $display("FAIL reset_initial: state=%0d enables=%b expected state=0 enables=00000",
                     state, {pc_en, ir_write, mem_write, reg_write, illegal_op});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd0 || {pc_en, ir_write, mem_write, reg_write, illegal_op} !== 5'b0) begin
            errors++;
            $display("FAIL reset_held: state=%0d enables=%b expected state=0 enables=00000",
                     state, {pc_en, ir_write, mem_write, reg_write, illegal_op});
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 0, "lw");
        checks++;
        if (cnt_rw !== 1) begin
            errors++;
            $display("FAIL lw_reg_write_count: got %0d expected 1", cnt_rw);
        end
        run_instr(6'b100011, 6'b100000, 1'b1, 2, 3, "lw_stall");
    endtask

    task automatic test_sw_stall();
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 3, "sw");
        checks++;
        if (cnt_mw !== 4 || cnt_rw !== 0) begin
            errors++;
            $display("FAIL sw_strobes: mem_write cycles=%0d reg_write cycles=%0d expected 4 and 0", cnt_mw, cnt_rw);
        end
    endtask

    task automatic test_beq();
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_taken");
        checks++;
        if (cnt_pc !== 2) begin
            errors++;
            $display("FAIL beq_taken_pc_en: got %0d cycles expected 2", cnt_pc);
        end
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_not_taken");
        checks++;
        if (cnt_pc !== 1) begin
            errors++;
            $display("FAIL beq_not_taken_pc_en: got %0d cycles expected 1", cnt_pc);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns [6];
        fns = '{6'b101010, 6'b000000, 6'b100000, 6'b100010, 6'b100100, 6'b100101};
        foreach (fns[k]) run_instr(6'b000000, fns[k], 1'b0, 0, 0, "rtype");
        run_instr(6'b001000, 6'b000000, 1'b0, 1, 0, "addi");
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, "jump");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, "illegal");
        checks++;
        if (cnt_il !== 1 || cnt_mw !== 0 || cnt_rw !== 0) begin
            errors++;
            $display("FAIL illegal_pulse: illegal=%0d mem_write=%0d reg_write=%0d expected 1,0,0",
                     cnt_il, cnt_mw, cnt_rw);
        end
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            fn = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'b100000 | 6'($urandom_range(0, 10));
            run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_async_reset();
        opcode = 6'b100011; funct = '0; zero = 1'b0;
        repeat (3) begin
            @(negedge clk);
            mem_ready = 1'b1;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 4'd3) begin
            errors++;
            $display("FAIL async_setup: got state %0d expected 3", state);
        end
        #1;
        rst_n = 1'b0;
        #1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || {pc_en, ir_write, mem_write, reg_write, illegal_op} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: state=%0d enables=%b expected 0 and 00000",
                     state, {pc_en, ir_write, mem_write, reg_write, illegal_op});
        end
        @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd0 || {pc_en, ir_write, mem_write, reg_write, illegal_op} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset_across_edge: state=%0d enables=%b expected 0 and 00000",
                     state, {pc_en, ir_write, mem_write, reg_write, illegal_op});
        end
        @(negedge clk);
        opcode = 6'b111111;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL first_fetch_after_release: got state %0d expected 1", state);
        end
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL return_after_release: got state %0d expected 0", state);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_rtype();
        test_illegal();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
